// File: rtl/spi_master_fifo.sv
// SPI master with TX/RX FIFOs: configurable frame width, FIFO depth, SCLK divider,
// clock mode and bit order. Mode and bit order are latched per frame.

module spi_master_fifo_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        full_d  = (count_d == (AW+1)'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: the empty flag gates what is visible at the head.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o  = empty_q ? '0 : mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
endmodule

module spi_master_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int DIV    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              write_i,
    output logic              tx_full_o,
    output logic              tx_empty_o,
    input  logic              read_i,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_full_o,
    output logic              rx_empty_o,
    output logic              rx_ovf_o,
    input  logic              en_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              lsb_first_i,
    output logic              busy_o,
    output logic              cs_n_o,
    output logic              sclk_o,
    output logic              mosi_o,
    input  logic              miso_i
);
    localparam int ECW  = $clog2(2*DATA_W + 1);
    localparam int DCW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [ECW-1:0] LAST_EDGE = ECW'(2*DATA_W);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

    state_e            state_q, state_d;
    logic [DCW-1:0]    div_cnt_q, div_cnt_d;
    logic [ECW-1:0]    edge_cnt_q, edge_cnt_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;
    logic              busy_q, busy_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic              lsb_q, lsb_d;
    logic              rx_ovf_q, rx_ovf_d;

    logic              div_last;
    logic              do_edge;
    logic              tx_pop;
    logic              rx_push;
    logic [DATA_W-1:0] tx_head;
    logic              tx_empty;
    logic              rx_full;
    logic              rx_empty;

    function automatic logic head_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b,
                                                   input logic lsb);
        return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
    endfunction

    spi_master_fifo_buf #(.W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (write_i),
        .data_i  (tx_data_i),
        .pop_i   (tx_pop),
        .head_o  (tx_head),
        .full_o  (tx_full_o),
        .empty_o (tx_empty)
    );

    spi_master_fifo_buf #(.W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rx_push),
        .data_i  (rx_sr_q),
        .pop_i   (read_i),
        .head_o  (rx_data_o),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    assign div_last = (div_cnt_q == DCW'(DIV - 1));

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        edge_cnt_d = edge_cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        busy_d     = busy_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        rx_ovf_d   = rx_ovf_q;
        tx_pop     = 1'b0;
        rx_push    = 1'b0;
        do_edge    = 1'b0;

        case (state_q)
            IDLE: begin
                sclk_d = cpol_i;
                cs_n_d = 1'b1;
                busy_d = 1'b0;
                if (en_i && !tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_sr_d    = tx_head;
                    rx_sr_d    = '0;
                    cpol_d     = cpol_i;
                    cpha_d     = cpha_i;
                    lsb_d      = lsb_first_i;
                    cs_n_d     = 1'b0;
                    busy_d     = 1'b1;
                    div_cnt_d  = '0;
                    edge_cnt_d = '0;
                    state_d    = SETUP;
                    if (!cpha_i) begin
                        mosi_d = head_bit(tx_head, lsb_first_i);
                    end
                end
            end
            SETUP: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    do_edge   = 1'b1;
                    state_d   = SHIFT;
                end else begin
                    div_cnt_d = div_cnt_q + DCW'(1);
                end
            end
            SHIFT: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    if (edge_cnt_q == LAST_EDGE) begin
                        state_d = HOLD;
                    end else begin
                        do_edge = 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DCW'(1);
                end
            end
            HOLD: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    cs_n_d    = 1'b1;
                    rx_push   = 1'b1;
                    state_d   = GAP;
                end else begin
                    div_cnt_d = div_cnt_q + DCW'(1);
                end
            end
            GAP: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    div_cnt_d = div_cnt_q + DCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Even edge counts precede a leading edge; CPHA selects whether that edge samples or drives.
        if (do_edge) begin
            sclk_d     = ~sclk_q;
            edge_cnt_d = edge_cnt_q + ECW'(1);
            if (edge_cnt_q[0] == cpha_q) begin
                rx_sr_d = shift_in(rx_sr_q, miso_i, lsb_q);
            end else if (cpha_q) begin
                mosi_d  = head_bit(tx_sr_q, lsb_q);
                tx_sr_d = shift_out(tx_sr_q, lsb_q);
            end else if (edge_cnt_q != LAST_EDGE - ECW'(1)) begin
                tx_sr_d = shift_out(tx_sr_q, lsb_q);
                mosi_d  = head_bit(shift_out(tx_sr_q, lsb_q), lsb_q);
            end
        end

        if (rx_push && rx_full) begin
            rx_ovf_d = 1'b1;
        end else if (read_i && !rx_empty) begin
            rx_ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            edge_cnt_q <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            rx_ovf_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            rx_ovf_q   <= rx_ovf_d;
        end
    end

    assign tx_empty_o = tx_empty;
    assign rx_full_o  = rx_full;
    assign rx_empty_o = rx_empty;
    assign rx_ovf_o   = rx_ovf_q;
    assign busy_o     = busy_q;
    assign cs_n_o     = cs_n_q;
    assign sclk_o     = sclk_q;
    assign mosi_o     = mosi_q;
endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed bench for spi_master_fifo: loopback in all modes, LSB-first with a slave
// model, FIFO full/overflow behaviour and asynchronous reset mid-frame.

module tb_spi_master_fifo;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int DIV    = 2;

    logic              clk = 1'b0;
    logic              rstN;
    logic [DATA_W-1:0] txData;
    logic              writeEn;
    logic              txFull;
    logic              txEmpty;
    logic              readEn;
    logic [DATA_W-1:0] rxData;
    logic              rxFull;
    logic              rxEmpty;
    logic              rxOvf;
    logic              en;
    logic              cpol;
    logic              cpha;
    logic              lsbFirst;
    logic              busy;
    logic              csN;
    logic              sclk;
    logic              mosi;
    logic              miso;

    logic              useModel;
    logic              modelMiso;
    logic [7:0]        modelWord;
    int                modelIdx;

    int total = 0;
    int bad   = 0;

    assign miso = useModel ? modelMiso : mosi;

    always #5 clk = ~clk;

    spi_master_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DIV(DIV)) dut (
        .clk         (clk),
        .rst_n       (rstN),
        .tx_data_i   (txData),
        .write_i     (writeEn),
        .tx_full_o   (txFull),
        .tx_empty_o  (txEmpty),
        .read_i      (readEn),
        .rx_data_o   (rxData),
        .rx_full_o   (rxFull),
        .rx_empty_o  (rxEmpty),
        .rx_ovf_o    (rxOvf),
        .en_i        (en),
        .cpol_i      (cpol),
        .cpha_i      (cpha),
        .lsb_first_i (lsbFirst),
        .busy_o      (busy),
        .cs_n_o      (csN),
        .sclk_o      (sclk),
        .mosi_o      (mosi),
        .miso_i      (miso)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] word);
        txData  = word;
        writeEn = 1'b1;
        @(negedge clk);
        writeEn = 1'b0;
    endtask

    task automatic popRx();
        readEn = 1'b1;
        @(negedge clk);
        readEn = 1'b0;
    endtask

    task automatic waitIdle(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
    endtask

    task automatic countFrames(input int cycles, output int n);
        logic prev;
        prev = csN;
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (prev && !csN) n++;
            prev = csN;
        end
    endtask

    // Leading-edge MOSI bits are collected first-bit-in-MSB; the slave model shifts on trailing edges.
    task automatic measureFrame(input logic idleLvl, output int lowCycles, output int edges,
                                output logic [7:0] capBits, output logic started);
        logic prev;
        started   = 1'b0;
        lowCycles = 0;
        edges     = 0;
        capBits   = '0;
        for (int i = 0; i < 300 && !started; i++) begin
            @(negedge clk);
            if (!csN) started = 1'b1;
        end
        if (started) begin
            prev = sclk;
            while (!csN && lowCycles < 1000) begin
                lowCycles++;
                @(negedge clk);
                if (sclk != prev) begin
                    edges++;
                    if (sclk != idleLvl) begin
                        capBits = {capBits[6:0], mosi};
                    end else if (useModel && modelIdx < 7) begin
                        modelIdx++;
                        modelMiso = modelWord[modelIdx];
                    end
                end
                prev = sclk;
            end
        end
    endtask

    initial begin
        int          low;
        int          edges;
        int          frames;
        logic [7:0]  cap;
        logic        started;
        logic        ok;
        logic        fell;
        logic [1:0]  mode;

        rstN      = 1'b0;
        txData    = '0;
        writeEn   = 1'b0;
        readEn    = 1'b0;
        en        = 1'b0;
        cpol      = 1'b0;
        cpha      = 1'b0;
        lsbFirst  = 1'b0;
        useModel  = 1'b0;
        modelMiso = 1'b0;
        modelWord = '0;
        modelIdx  = 0;

        repeat (3) @(negedge clk);
        checkOutput("rstTxEmpty", txEmpty, 1);
        checkOutput("rstRxEmpty", rxEmpty, 1);
        checkOutput("rstTxFull", txFull, 0);
        checkOutput("rstRxFull", rxFull, 0);
        checkOutput("rstRxOvf", rxOvf, 0);
        checkOutput("rstRxData", rxData, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstCsN", csN, 1);
        checkOutput("rstSclk", sclk, 0);
        checkOutput("rstMosi", mosi, 0);
        rstN = 1'b1;
        @(negedge clk);

        $display("[TB] loopback mode 0, two frames");
        applyStimulus(8'h43);
        applyStimulus(8'h5F);
        checkOutput("txNotEmpty", txEmpty, 0);
        en = 1'b1;
        measureFrame(1'b0, low, edges, cap, started);
        checkOutput("f1Start", started, 1);
        checkOutput("f1Low", low, 36);
        checkOutput("f1Edges", edges, 16);
        checkOutput("f1Mosi", cap, 8'h43);
        measureFrame(1'b0, low, edges, cap, started);
        checkOutput("f2Start", started, 1);
        checkOutput("f2Low", low, 36);
        checkOutput("f2Mosi", cap, 8'h5F);
        waitIdle(ok);
        checkOutput("f2Idle", ok, 1);
        en = 1'b0;
        checkOutput("lbRx0", rxData, 8'h43);
        popRx();
        checkOutput("lbRx1", rxData, 8'h5F);
        popRx();
        checkOutput("lbRxEmpty", rxEmpty, 1);

        $display("[TB] all four clock modes with 0xA5");
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            cpol = mode[1];
            cpha = mode[0];
            repeat (2) @(negedge clk);
            checkOutput($sformatf("mode%0dIdleSclk", m), sclk, cpol);
            applyStimulus(8'hA5);
            en = 1'b1;
            measureFrame(cpol, low, edges, cap, started);
            en = 1'b0;
            checkOutput($sformatf("mode%0dLow", m), low, 36);
            checkOutput($sformatf("mode%0dEdges", m), edges, 16);
            waitIdle(ok);
            checkOutput($sformatf("mode%0dIdle", m), ok, 1);
            checkOutput($sformatf("mode%0dEndSclk", m), sclk, cpol);
            checkOutput($sformatf("mode%0dRx", m), rxData, 8'hA5);
            popRx();
        end

        $display("[TB] LSB first against slave model");
        cpol     = 1'b0;
        cpha     = 1'b0;
        lsbFirst = 1'b1;
        repeat (2) @(negedge clk);
        modelWord = 8'hC3;
        modelIdx  = 0;
        modelMiso = modelWord[0];
        useModel  = 1'b1;
        applyStimulus(8'h01);
        en = 1'b1;
        measureFrame(1'b0, low, edges, cap, started);
        en = 1'b0;
        checkOutput("lsbMosiBits", cap, 8'h80);
        waitIdle(ok);
        useModel = 1'b0;
        lsbFirst = 1'b0;
        checkOutput("lsbRx", rxData, 8'hC3);
        popRx();
        checkOutput("lsbRxEmpty", rxEmpty, 1);

        $display("[TB] TX fill, RX full and overflow");
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        checkOutput("txFull3", txFull, 0);
        applyStimulus(8'h44);
        checkOutput("txFull4", txFull, 1);
        applyStimulus(8'h55);
        checkOutput("txFull5", txFull, 1);
        en = 1'b1;
        countFrames(250, frames);
        checkOutput("fillFrames", frames, 4);
        checkOutput("fillTxEmpty", txEmpty, 1);
        checkOutput("fillBusy", busy, 0);
        checkOutput("fillRxFull", rxFull, 1);
        checkOutput("fillRxOvf", rxOvf, 0);
        checkOutput("fillRxHead", rxData, 8'h11);
        applyStimulus(8'h66);
        measureFrame(1'b0, low, edges, cap, started);
        checkOutput("ovfStart", started, 1);
        waitIdle(ok);
        en = 1'b0;
        checkOutput("ovfSet", rxOvf, 1);
        checkOutput("ovfHead", rxData, 8'h11);
        popRx();
        checkOutput("ovfClear", rxOvf, 0);
        checkOutput("ovfRx1", rxData, 8'h22);
        checkOutput("ovfNotFull", rxFull, 0);
        popRx();
        checkOutput("ovfRx2", rxData, 8'h33);
        popRx();
        checkOutput("ovfRx3", rxData, 8'h44);
        popRx();
        checkOutput("ovfDrained", rxEmpty, 1);

        $display("[TB] reset mid-frame");
        cpol = 1'b1;
        cpha = 1'b0;
        repeat (2) @(negedge clk);
        applyStimulus(8'h77);
        applyStimulus(8'h78);
        en = 1'b1;
        fell = 1'b0;
        for (int i = 0; i < 50 && !fell; i++) begin
            @(negedge clk);
            if (!csN) fell = 1'b1;
        end
        checkOutput("rstFrameStart", fell, 1);
        repeat (9) @(negedge clk);
        checkOutput("preRstBusy", busy, 1);
        checkOutput("preRstSclk", sclk, 1);
        rstN = 1'b0;
        #1;
        checkOutput("midRstCsN", csN, 1);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstSclk", sclk, 0);
        checkOutput("midRstTxEmpty", txEmpty, 1);
        checkOutput("midRstRxEmpty", rxEmpty, 1);
        en = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        repeat (60) @(negedge clk);
        checkOutput("postRstRxEmpty", rxEmpty, 1);
        checkOutput("postRstCsN", csN, 1);
        checkOutput("postRstTxEmpty", txEmpty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_master_fifo.md
Name: spi_master_fifo

Overview:
Parametrised SPI master with transmit and receive FIFOs, for the SPI interface block. Data width, FIFO depth, SCLK divider, clock mode (CPOL/CPHA) and bit order are configurable. Words written into the TX FIFO are shifted out on MOSI. The word simultaneously captured on MISO for each frame is pushed into the RX FIFO. Full/empty status and a sticky RX overflow flag are provided for the host side.

Parameters:
DATA_W, 8, bits per SPI frame and FIFO word width (2..32)
DEPTH, 4, entries per FIFO (power of 2, >=2)
DIV, 2, CLK cycles per SCLK half-period (>=1)

Ports:
CLK  input  1  system clock, all logic on rising edge
CLR  input  1  asynchronous active-low reset
TX_DATA  input  DATA_W  word to enqueue
WRITE  input  1  push TX_DATA into TX FIFO (one word per CLK cycle high)
TX_FULL  output  1  TX FIFO holds DEPTH words
TX_EMPTY  output  1  TX FIFO holds 0 words
READ  input  1  pop RX FIFO head
RX_DATA  output  DATA_W  RX FIFO head (first-word-fall-through), 0 when empty
RX_FULL  output  1  RX FIFO holds DEPTH words
RX_EMPTY  output  1  RX FIFO holds 0 words
RX_OVF  output  1  sticky: a received word was dropped
EN  input  1  transfer enable
CPOL  input  1  SCLK idle level
CPHA  input  1  0: sample on leading edge; 1: sample on trailing edge
LSB_FIRST  input  1  0: MSB first; 1: LSB first
BUSY  output  1  frame in progress
CS_N  output  1  chip select, active low
SCLK  output  1  serial clock
MOSI  output  1  serial data out
MISO  input  1  serial data in

Behaviour:
- Reset (CLR=0, async): both FIFOs emptied, pointers 0; TX_EMPTY=1, RX_EMPTY=1, TX_FULL=0, RX_FULL=0, RX_OVF=0, RX_DATA=0, BUSY=0, CS_N=1, SCLK=0, MOSI=0, FSM=IDLE. Reset mid-frame aborts the frame; no partial word is pushed.
- FIFOs: WRITE while TX_FULL is ignored; READ while RX_EMPTY is ignored. Simultaneous push and pop on a non-full/non-empty FIFO keeps the count unchanged. Status flags are registered and valid the cycle after the push/pop edge.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: SCLK=CPOL, CS_N=1. When EN=1 and TX_EMPTY=0: pop the TX head into the shift register and latch CPOL/CPHA/LSB_FIRST for the frame. On the next cycle CS_N=0, BUSY=1, go to SETUP.
- SETUP: lasts DIV cycles. If CPHA=0, MOSI carries the first bit from CS_N fall.
- SHIFT: SCLK toggles every DIV cycles, giving 2*DATA_W edges.
  - CPHA=0: sample MISO on each leading edge; drive the next bit on each trailing edge.
  - CPHA=1: drive on each leading edge; sample on each trailing edge.
  - Bit order follows the latched LSB_FIRST.
- HOLD: DIV cycles with SCLK=CPOL and CS_N=0. Then CS_N=1 and the assembled word is pushed to the RX FIFO.
- RX push while RX_FULL: word dropped, RX_OVF=1. RX_OVF clears only when an accepted READ occurs.
- GAP: DIV cycles with CS_N=1, BUSY=1, then IDLE. BUSY falls on entry to IDLE.
- Back-to-back frames: IDLE immediately starts the next frame if EN=1 and TX is non-empty.
- EN dropping mid-frame: the current frame completes, and no further frame starts.
- Changing CPOL/CPHA/LSB_FIRST mid-frame has no effect until the next frame.
- Frame length from CS_N fall to CS_N rise is (2*DATA_W+2)*DIV cycles.
- MOSI holds its last value when idle.

Test Plan:
- Loopback (MISO=MOSI), DATA_W=8, DIV=2, mode 0, MSB first: write 0x43 then 0x5F, EN=1 -> two frames, CS_N low 36 CLK each; RX_DATA=0x43, READ -> 0x5F, READ -> RX_EMPTY=1.
- All four CPOL/CPHA combos with loopback word 0xA5 -> SCLK idles at CPOL, 16 edges per frame, received word 0xA5 in every mode.
- LSB_FIRST=1, MISO tied to external model, TX 0x01 -> MOSI first bit 1 followed by seven 0s; model word 0xC3 sent LSB first -> RX_DATA=0xC3.
- Fill TX with DEPTH+1 writes while EN=0 -> TX_FULL=1 after 4 writes, 5th discarded; EN=1 -> exactly 4 frames, then TX_EMPTY=1, BUSY=0.
- Five loopback frames without READ -> RX_FULL after 4, RX_OVF=1 after 5th, RX_DATA = first word; one READ -> RX_OVF=0.
- CLR pulsed low mid-SHIFT -> CS_N=1, BUSY=0, SCLK=0, FIFOs empty immediately; no RX push after release.
